// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Brief    : Ping-pong buffer that reorders bit-reversed FFT bins to natural
//            order. Optional out_idx port when FFT_REORDER_IDX_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module fft_bitrev_reorder #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic                     out_valid,
  output logic                     out_first,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i
`ifdef FFT_REORDER_IDX_EN
  ,
  output logic [N_LOG2-1:0]        out_idx
`endif
);

  localparam int                c_N       = 2**N_LOG2;
  localparam logic [N_LOG2-1:0] c_LAST    = '1;
  localparam logic [0:0]        c_ST_IDLE = 1'b0;
  localparam logic [0:0]        c_ST_READ = 1'b1;

  logic [2*DATA_W-1:0] r_mem [0:2*c_N-1];

  logic [N_LOG2-1:0]   r_wcnt;
  logic                r_wsel;
  logic [N_LOG2-1:0]   r_rcnt;
  logic                r_rsel;
  logic [0:0]          r_state;

  logic [N_LOG2-1:0]   w_rcnt_nxt;
  logic                w_rsel_nxt;
  logic [0:0]          w_state_nxt;
  logic                w_launch;
  logic                w_rd_end;
  logic                w_rd_act;
  logic [2*DATA_W-1:0] w_rd_word;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] res;
    for (int b = 0; b < N_LOG2; b++) begin
      res[b] = a[N_LOG2-1-b];
    end
    return res;
  endfunction

  assign w_launch = in_valid && (r_wcnt == c_LAST);
  assign w_rd_end = (r_state == c_ST_READ) && (r_rcnt == c_LAST);

  // Write side: bank address is {bank, bit-reversed sample count}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
      r_wsel <= 1'b0;
    end else if (in_valid) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (r_wcnt == c_LAST) begin
        r_wsel <= ~r_wsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[{r_wsel, bitrev(r_wcnt)}] <= {in_r, in_i};
    end
  end

  // Next read position; the output registers are loaded from this position so
  // bin 0 leaves on the same edge that accepts the frame's last sample.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rsel_nxt  = r_rsel;
    if (w_launch && ((r_state == c_ST_IDLE) || w_rd_end)) begin
      w_state_nxt = c_ST_READ;
      w_rcnt_nxt  = '0;
      w_rsel_nxt  = r_wsel;
    end else if (r_state == c_ST_READ) begin
      if (w_rd_end) begin
        w_state_nxt = c_ST_IDLE;
        w_rcnt_nxt  = '0;
      end else begin
        w_rcnt_nxt  = r_rcnt + 1'b1;
      end
    end
  end

  assign w_rd_act  = (w_state_nxt == c_ST_READ);
  assign w_rd_word = r_mem[{w_rsel_nxt, w_rcnt_nxt}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_rcnt    <= '0;
      r_rsel    <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rsel    <= w_rsel_nxt;
      out_valid <= w_rd_act;
      out_first <= w_rd_act && (w_rcnt_nxt == '0);
      out_r     <= w_rd_act ? w_rd_word[2*DATA_W-1:DATA_W] : '0;
      out_i     <= w_rd_act ? w_rd_word[DATA_W-1:0]        : '0;
    end
  end

`ifdef FFT_REORDER_IDX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx <= '0;
    end else begin
      out_idx <= w_rd_act ? w_rcnt_nxt : '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder stage directly downstream of the 16-point streaming FFT core (fft_1d_8_kai_top).
- The core emits complex bins in bit-reversed order, one per clock. This block buffers each frame and re-emits it in natural bin order (bin 0 first).
- Uses a ping-pong buffer, so a continuous input stream produces a continuous output stream.

Parameters:
- N_LOG2, 4, log2 of frame length; N = 2**N_LOG2 (16 by default).
- DATA_W, 16, width of each real/imaginary component (matches the core's output bus).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_r/in_i carry a valid bin this cycle.
- in_r  in  DATA_W  signed real part, bit-reversed order.
- in_i  in  DATA_W  signed imaginary part, bit-reversed order.
- out_valid  out  1  out_r/out_i valid this cycle.
- out_first  out  1  high with bin 0 of each output frame.
- out_r  out  DATA_W  signed real part, natural order.
- out_i  out  DATA_W  signed imaginary part, natural order.

Behaviour:
- Storage: two banks (0/1) of N complex words each; wsel selects the write bank, the other bank is the read bank.
- Write side:
  - wcnt (N_LOG2 bits) counts accepted inputs.
  - On in_valid, store the sample at address bitrev(wcnt) in bank wsel, then increment wcnt.
  - When wcnt == N-1 and the sample is accepted: wcnt wraps to 0, wsel toggles, and a read of the just-filled bank is launched.
- Read side, two states:
  - IDLE: out_valid = 0. Go to READ on the launch pulse.
  - READ: rcnt runs 0..N-1, one word per cycle, address rcnt of the read bank. After rcnt == N-1, go back to IDLE, unless a new launch arrives the same cycle, in which case stay in READ with rcnt = 0 and the other bank.
- Output timing:
  - All outputs are registered.
  - Bin 0 appears on the cycle after the cycle that accepted the frame's last input. Latency from a frame's first input is N cycles for a gap-free stream.
  - Read runs N consecutive cycles regardless of in_valid gaps on the write side.
- out_first = 1 exactly when out_valid = 1 and rcnt == 0.
- Data is passed through unmodified: no scaling, no sign change, full DATA_W.
- Boundary cases:
  - in_valid gaps stall only the write side; partial frames wait indefinitely.
  - A back-to-back frame cannot overrun: filling takes at least N cycles, reading takes exactly N.
  - When the launch and the end of a read coincide, the output is seamless: the last bin of frame k is followed by bin 0 of frame k+1 on the next cycle.
- Reset (asynchronous, any time):
  - wcnt = 0, rcnt = 0, wsel = 0, state = IDLE.
  - out_valid = 0, out_first = 0, out_r = 0, out_i = 0.
  - Any partial or in-flight frame is discarded. Buffer contents need not be cleared.

Optional Feature:
- Macro: FFT_REORDER_IDX_EN.
- Defined: adds output port out_idx [N_LOG2-1:0], registered and aligned with out_valid, carrying the natural bin number (equal to rcnt). Reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Gap-free reorder: one frame, in_valid = 1 for 16 cycles, in_r = in_i = 256*k for sample k. Expect out_valid for 16 consecutive cycles starting the cycle after the last input, with out_r/256 = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_first = 1 on the first output cycle only.
- Back-to-back: three frames, 48 continuous inputs tagged in_r = frame*100 + k. Expect 48 continuous out_valid cycles with no bubble, out_first high at output cycles 0, 16 and 32, and values natural-ordered per frame.
- Input gaps: one frame with in_valid toggling 1,0,1,0… (32 cycles). Expect no output until the 16th sample is accepted, then 16 gap-free outputs with correct order.
- Signed data: in_r = -32768, in_i = 32767 at sample 1, zeros elsewhere. Expect out_r = -32768, out_i = 32767 at output index 8; all other outputs zero.
- Reset mid-frame: assert rst after 7 inputs, release, then send one full frame tagged 0..15. Expect all outputs 0 during reset, and only the new frame emitted, correctly ordered.
- With FFT_REORDER_IDX_EN defined: repeat the first test. Expect out_idx = 0..15 matching each output cycle, and out_idx = 0 while out_valid = 0 after reset.
